// File: rtl/store_write_buffer_if.sv
// Core/memory-side bundle for the store write buffer: store requests, load
// address for hazard lookup, and the head-entry memory port.
interface store_write_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          memwrite;
  logic [31:0]   dataadr;
  logic [31:0]   writedata;
  logic [1:0]    storesize;
  logic [31:0]   loadadr;
  logic          stall;
  logic          conflict;
  logic          memreq;
  logic [31:0]   memadr;
  logic [31:0]   memdata;
  logic [3:0]    membe;
  logic          memack;
  logic [CW-1:0] count;
  logic          misalign;

  modport master (
    output memwrite, dataadr, writedata, storesize, loadadr, memack,
    input  stall, conflict, memreq, memadr, memdata, membe, count, misalign
  );

  modport slave (
    input  memwrite, dataadr, writedata, storesize, loadadr, memack,
    output stall, conflict, memreq, memadr, memdata, membe, count, misalign
  );
endinterface

// File: rtl/store_write_buffer.sv
// Store write buffer: circular FIFO of lane-aligned stores draining to data
// memory in order, with a word-granular load-hazard lookup.
module store_write_buffer #(
  parameter int DEPTH = 4
) (
  input logic                 clk,
  input logic                 reset,
  store_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [29:0]      adr_mem  [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [3:0]       be_mem   [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic             misalign;

  logic             full;
  logic             aligned;
  logic             push;
  logic             pop;
  logic             conflict;
  logic [31:0]      new_data;
  logic [3:0]       new_be;
  logic             unused_bits;

  // Lane placement: data is replicated across lanes, byte enables select them.
  always_comb begin
    aligned  = 1'b1;
    new_be   = 4'b1111;
    new_data = bus.writedata;
    case (bus.storesize)
      2'b01: begin
        aligned  = ~bus.dataadr[0];
        new_be   = bus.dataadr[1] ? 4'b1100 : 4'b0011;
        new_data = {2{bus.writedata[15:0]}};
      end
      2'b10: begin
        new_be   = 4'b0001 << bus.dataadr[1:0];
        new_data = {4{bus.writedata[7:0]}};
      end
      default: aligned = (bus.dataadr[1:0] == 2'b00);
    endcase
  end

  assign full = (count == CW'(DEPTH));
  assign push = bus.memwrite & ~full & aligned;
  assign pop  = bus.memack & (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      adr_mem[tail]  <= bus.dataadr[31:2];
      data_mem[tail] <= new_data;
      be_mem[tail]   <= new_be;
    end
  end

  // Full-with-ack frees a slot only after the edge, so that cycle's store is rejected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      valid    <= '0;
      misalign <= 1'b0;
    end else begin
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      if (push) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (bus.memwrite & ~full & ~aligned)
        misalign <= 1'b1;
    end
  end

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (valid[i] && (adr_mem[i] == bus.loadadr[31:2]))
        conflict = 1'b1;
  end

  assign unused_bits  = ^bus.loadadr[1:0];

  assign bus.stall    = bus.memwrite & full;
  assign bus.conflict = conflict;
  assign bus.memreq   = (count != '0);
  assign bus.memadr   = bus.memreq ? {adr_mem[head], 2'b00} : 32'h0;
  assign bus.memdata  = bus.memreq ? data_mem[head] : 32'h0;
  assign bus.membe    = bus.memreq ? be_mem[head] : 4'b0000;
  assign bus.count    = count;
  assign bus.misalign = misalign;
endmodule

// File: tb/tb_store_write_buffer.sv
// Randomized scoreboard bench for store_write_buffer against a queue-based
// reference model of the buffer contents.
module tb_store_write_buffer;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  logic   clk;
  logic   reset;
  logic   acc;
  int     checks;
  int     failures;
  bit     model_misalign;
  entry_t model_q[$];
  entry_t exp_q[$];

  store_write_buffer_if #(.DEPTH(DEPTH)) bus();

  store_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_aligned(input logic [31:0] adr, input logic [1:0] sz);
    if (sz == 2'd1) return (adr % 2) == 0;
    if (sz == 2'd2) return 1'b1;
    return (adr % 4) == 0;
  endfunction

  function automatic entry_t make_entry(input logic [31:0] adr, input logic [31:0] wd, input logic [1:0] sz);
    entry_t e;
    int lane;
    lane  = int'(adr % 4);
    e.adr = adr - 32'(lane);
    if (sz == 2'd1) begin
      e.data = (wd & 32'h0000FFFF) * 32'h00010001;
      e.be   = 4'(3 << lane);
    end else if (sz == 2'd2) begin
      e.data = (wd & 32'h000000FF) * 32'h01010101;
      e.be   = 4'(1 << lane);
    end else begin
      e.data = wd;
      e.be   = 4'hF;
    end
    return e;
  endfunction

  // Retirement monitor: whatever the memory accepts must be the oldest issued store.
  always @(negedge clk) begin
    if (bus.memreq && bus.memack) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL retire_extra actual=%0h required=none at %0t", bus.memadr, $time);
      end else begin
        entry_t e;
        e = exp_q.pop_front();
        checkOutput("retire_adr", bus.memadr, e.adr);
        checkOutput("retire_data", bus.memdata, e.data);
        checkOutput("retire_be", 32'(bus.membe), 32'(e.be));
      end
    end
  end

  task automatic checkReset();
    checkOutput("rst_memreq", 32'(bus.memreq), 0);
    checkOutput("rst_memadr", bus.memadr, 0);
    checkOutput("rst_memdata", bus.memdata, 0);
    checkOutput("rst_membe", 32'(bus.membe), 0);
    checkOutput("rst_stall", 32'(bus.stall), 0);
    checkOutput("rst_conflict", 32'(bus.conflict), 0);
    checkOutput("rst_count", 32'(bus.count), 0);
    checkOutput("rst_misalign", 32'(bus.misalign), 0);
  endtask

  // One clock cycle: drive just after posedge, check at negedge, update model at posedge.
  task automatic applyStimulus(input logic mw, input logic [31:0] adr, input logic [31:0] wd,
                               input logic [1:0] sz, input logic [31:0] la, input logic ack,
                               output logic accepted);
    bit full;
    bit conf;
    entry_t e;
    bus.memwrite  = mw;
    bus.dataadr   = adr;
    bus.writedata = wd;
    bus.storesize = sz;
    bus.loadadr   = la;
    bus.memack    = ack;
    full = (model_q.size() == DEPTH);
    conf = 1'b0;
    foreach (model_q[i])
      if ((model_q[i].adr >> 2) == (la >> 2)) conf = 1'b1;
    @(negedge clk);
    checkOutput("stall", 32'(bus.stall), 32'(mw && full));
    checkOutput("count", 32'(bus.count), 32'(model_q.size()));
    checkOutput("memreq", 32'(bus.memreq), 32'(model_q.size() != 0));
    checkOutput("conflict", 32'(bus.conflict), 32'(conf));
    checkOutput("misalign", 32'(bus.misalign), 32'(model_misalign));
    if (model_q.size() != 0) begin
      checkOutput("head_adr", bus.memadr, model_q[0].adr);
      checkOutput("head_data", bus.memdata, model_q[0].data);
      checkOutput("head_be", 32'(bus.membe), 32'(model_q[0].be));
    end else begin
      checkOutput("idle_adr", bus.memadr, 0);
      checkOutput("idle_data", bus.memdata, 0);
      checkOutput("idle_be", 32'(bus.membe), 0);
    end
    @(posedge clk);
    if (ack && model_q.size() != 0) void'(model_q.pop_front());
    accepted = mw && !full && is_aligned(adr, sz);
    if (accepted) begin
      e = make_entry(adr, wd, sz);
      model_q.push_back(e);
      exp_q.push_back(e);
    end
    if (mw && !full && !is_aligned(adr, sz)) model_misalign = 1'b1;
    #1;
  endtask

  task automatic drain();
    logic a;
    for (int n = 0; n < 3 * DEPTH && model_q.size() != 0; n++)
      applyStimulus(1'b0, 32'h0, 32'h0, 2'd0, 32'h0, 1'b1, a);
    applyStimulus(1'b0, 32'h0, 32'h0, 2'd0, 32'h0, 1'b1, a);
    checkOutput("drain_leftover", 32'(exp_q.size()), 0);
  endtask

  task automatic doReset();
    reset = 1'b0;
    #1;
    checkReset();
    model_q.delete();
    exp_q.delete();
    model_misalign = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_misalign = 1'b0;
    reset = 1'b0;
    bus.memwrite = 1'b0;
    bus.dataadr = 32'h0;
    bus.writedata = 32'h0;
    bus.storesize = 2'd0;
    bus.loadadr = 32'h0;
    bus.memack = 1'b0;
    #2;
    checkReset();
    @(posedge clk);
    #1;
    reset = 1'b1;

    $display("[TB] word store and ack");
    applyStimulus(1'b1, 32'd84, 32'hFFFF7F02, 2'd0, 32'h0, 1'b0, acc);
    applyStimulus(1'b0, 32'd0, 32'h0, 2'd0, 32'h0, 1'b1, acc);
    applyStimulus(1'b0, 32'd0, 32'h0, 2'd0, 32'h0, 1'b0, acc);

    $display("[TB] byte and halfword placement");
    applyStimulus(1'b1, 32'd83, 32'h000000A5, 2'd2, 32'h0, 1'b0, acc);
    applyStimulus(1'b1, 32'd82, 32'h00001234, 2'd1, 32'h0, 1'b0, acc);
    applyStimulus(1'b1, 32'd80, 32'h0000BEEF, 2'd1, 32'h0, 1'b0, acc);
    drain();

    $display("[TB] fill, stall, retry");
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, 32'(100 + 4 * i), 32'(32'hC0DE0000 + i), 2'd0, 32'h0, 1'b0, acc);
    applyStimulus(1'b1, 32'd200, 32'hC0DE0005, 2'd0, 32'h0, 1'b0, acc);
    acc = 1'b0;
    for (int n = 0; n < 8 && !acc; n++)
      applyStimulus(1'b1, 32'd200, 32'hC0DE0005, 2'd0, 32'h0, 1'b1, acc);
    drain();

    $display("[TB] misaligned stores");
    applyStimulus(1'b1, 32'd81, 32'h11111111, 2'd0, 32'h0, 1'b0, acc);
    applyStimulus(1'b1, 32'd81, 32'h00002222, 2'd1, 32'h0, 1'b0, acc);
    applyStimulus(1'b0, 32'd0, 32'h0, 2'd0, 32'h0, 1'b0, acc);

    $display("[TB] load conflict");
    applyStimulus(1'b1, 32'd84, 32'h55667788, 2'd0, 32'd86, 1'b0, acc);
    applyStimulus(1'b0, 32'd0, 32'h0, 2'd0, 32'd86, 1'b0, acc);
    applyStimulus(1'b0, 32'd0, 32'h0, 2'd0, 32'd88, 1'b1, acc);
    applyStimulus(1'b0, 32'd0, 32'h0, 2'd0, 32'd86, 1'b0, acc);

    $display("[TB] reset with pending entries");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'(40 + 4 * i), 32'(32'hABC00000 + i), 2'd0, 32'h0, 1'b0, acc);
    doReset();
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 32'd0, 32'h0, 2'd0, 32'd40, 1'b1, acc);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      logic [31:0] adr;
      logic [1:0]  sz;
      sz  = 2'($urandom_range(0, 3));
      adr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) != 0) begin
        if (sz == 2'd1) adr = adr & ~32'd1;
        else if (sz != 2'd2) adr = adr & ~32'd3;
      end
      applyStimulus(1'($urandom_range(0, 1)), adr, $urandom, sz,
                    32'($urandom_range(0, 63)), 1'($urandom_range(0, 2) == 0), acc);
      if (n == 200) doReset();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/store_write_buffer.md
STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
REQ-001 Parameter: DEPTH, 4, number of buffered store entries (power of two, 2..16).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 memwrite  in  1  store request from core, sampled each rising edge.
REQ-005 dataadr  in  32  store byte address from core.
REQ-006 writedata  in  32  store data from core, right-justified for byte/halfword.
REQ-007 storesize  in  2  00 word, 01 halfword, 10 byte, 11 treated as word.
REQ-008 loadadr  in  32  address of load currently in execute.
REQ-009 stall  out  1  core must hold its store; the store is not accepted this cycle.
REQ-010 conflict  out  1  some pending entry targets the same word as loadadr.
REQ-011 memreq  out  1  head entry valid, presented to data memory.
REQ-012 memadr  out  32  head entry word address, bits [1:0] = 00.
REQ-013 memdata  out  32  head entry lane-aligned data.
REQ-014 membe  out  4  head entry byte enables, bit k = byte lane k.
REQ-015 memack  in  1  memory accepted the head entry this cycle.
REQ-016 count  out  clog2(DEPTH)+1  number of valid entries.
REQ-017 misalign  out  1  sticky flag: a misaligned store was dropped.

Function
REQ-018 Circular FIFO of DEPTH entries {word address, data, byte enables}; head/tail pointers wrap modulo DEPTH.
REQ-019 Push: memwrite=1, count<DEPTH, address aligned -> entry written at tail on the rising edge; tail and count advance.
REQ-020 stall = memwrite & (count==DEPTH), combinational; no push occurs while stall=1.
REQ-021 Full + memack in the same cycle: pop occurs, push is rejected (stall stays 1 that cycle); the core's retry is accepted next cycle.
REQ-022 memreq = (count!=0); memadr/memdata/membe driven from head entry, all zero when count=0.
REQ-023 Pop: memreq & memack on a rising edge -> head and count advance; memack with count=0 is ignored.
REQ-024 Simultaneous push and pop with 0<count<DEPTH -> count unchanged, both pointers advance.
REQ-025 Push into an empty buffer: memreq rises one cycle after the accepting edge (no bypass; minimum latency 1 cycle).
REQ-026 Word store: membe=1111, memdata=writedata; requires dataadr[1:0]=00.
REQ-027 Halfword store: requires dataadr[0]=0; memdata={writedata[15:0],writedata[15:0]}; membe=0011 for dataadr[1]=0, 1100 for dataadr[1]=1.
REQ-028 Byte store: memdata=writedata[7:0] replicated in all four lanes; membe has only bit dataadr[1:0] set.
REQ-029 Misaligned store (violates REQ-026/027): no entry written, stall=0, misalign set on that edge and held until reset.
REQ-030 conflict = OR over valid entries of (entry address[31:2]==loadadr[31:2]), combinational; independent of byte enables.
REQ-031 Entries retire strictly in acceptance order; no merging or reordering.

Reset
REQ-032 reset=0 asynchronously clears head, tail, count, misalign; memreq=0, memadr=0, memdata=0, membe=0000, stall=0, conflict=0 immediately.
REQ-033 Reset mid-operation discards all pending entries; no memreq is issued for them after release.
REQ-034 First push may be accepted on the first rising edge after reset deasserts.

Verification
REQ-035 Word store dataadr=84, writedata=32'hFFFF7F02, memwrite one cycle, memack=1 -> next cycle memreq=1, memadr=84, memdata=32'hFFFF7F02, membe=1111; count returns to 0 after the ack edge.
REQ-036 Byte store dataadr=83, writedata=32'h000000A5 -> memadr=80, memdata=32'hA5A5A5A5, membe=1000; halfword at 82, data 32'h1234 -> memdata=32'h12341234, membe=1100.
REQ-037 memack held 0, five consecutive word stores -> count saturates at 4, stall=1 on the fifth; release memack -> entries drain in order, fifth store accepted on the retry edge.
REQ-038 Store to 81 as word -> no entry, count stays 0, misalign=1 until reset; halfword to 81 same result.
REQ-039 Entry pending at 84, loadadr=86 -> conflict=1; loadadr=88 -> conflict=0; after pop with loadadr=86 -> conflict=0.
REQ-040 Three entries pending, reset driven low between clock edges -> count=0, memreq=0 before next edge; no memreq after reset release.
